// File: rtl/ibex_pkg_pext.sv
// Shared types for the P-extension 16x16 multiply/MAC group: the decoded
// operator, the multiplier FSM states and the per-operator control fields.
package ibex_pkg_pext;

   // Decoded operators of the 16x16 multiply group, plus two operators that
   // belong to other P-ext units and are unsupported here.
   typedef enum logic [5:0] {
      ZPN_SMBB16, ZPN_SMBT16, ZPN_SMTT16,
      ZPN_KMABB,  ZPN_KMABT,  ZPN_KMATT,
      ZPN_KHMBB,  ZPN_KHMBT,  ZPN_KHMTT,
      ZPN_KDMBB,  ZPN_KDMBT,  ZPN_KDMTT,
      ZPN_KDMABB, ZPN_KDMABT, ZPN_KDMATT,
      ZPN_KMDA,   ZPN_KMXDA,
      ZPN_SMDS,   ZPN_SMXDS,  ZPN_SMDRS,
      ZPN_KMADA,  ZPN_KMAXDA,
      ZPN_KMADS,  ZPN_KMAXDS, ZPN_KMADRS,
      ZPN_KMSDA,  ZPN_KMSXDA,
      ZPN_KHM16,  ZPN_KHMX16,
      ZPN_ADD16,  ZPN_SUB16
   } zpn_op_e;

   typedef enum logic [1:0] {
      MULT16_IDLE, MULT16_MUL0, MULT16_MUL1, MULT16_DONE
   } mult16_state_e;

   // Half-word pair feeding the multiplier: first letter selects the half
   // of rs1, second letter the half of rs2 (B = bottom, T = top).
   typedef enum logic [1:0] {
      HSEL_BB, HSEL_BT, HSEL_TB, HSEL_TT
   } mult16_hsel_e;

   // How one term (c, p0 or p1) enters the 34-bit accumulator.
   typedef enum logic [1:0] {
      COMB_NONE, COMB_ADD, COMB_SUB
   } mult16_comb_e;

   // Final clamp applied to the combined value.
   typedef enum logic [1:0] {
      SAT_NONE, SAT_16_Q15, SAT_32, SAT_DBL_32
   } mult16_sat_e;

   typedef struct packed {
      logic         supported;
      logic         two_prod;
      logic         lane_pack;
      mult16_hsel_e hsel0;
      mult16_hsel_e hsel1;
      mult16_comb_e comb_c;
      mult16_comb_e comb_p0;
      mult16_comb_e comb_p1;
      mult16_sat_e  sat;
   } mult16_ctrl_t;

endpackage

// File: rtl/ibex_pext_sat.sv
// Signed clamp of a 34-bit value to 32 and to 16 bits, each with a flag
// that is set only when the clamp changed the value.
module ibex_pext_sat (
   input  logic signed [33:0] value,
   output logic        [31:0] sat32,
   output logic               ov32,
   output logic        [15:0] sat16,
   output logic               ov16
);

   // Value fits when all bits above the target sign bit equal the sign.
   always_comb begin
      ov32  = !((&value[33:31]) || !(|value[33:31]));
      sat32 = ov32 ? (value[33] ? 32'h8000_0000 : 32'h7fff_ffff) : value[31:0];
      ov16  = !((&value[33:15]) || !(|value[33:15]));
      sat16 = ov16 ? (value[33] ? 16'h8000 : 16'h7fff) : value[15:0];
   end

endmodule

// File: rtl/ibex_pext_mult16.sv
// Multi-cycle 16x16 SIMD multiply/MAC unit. One shared signed 16x16
// multiplier is used once (single-product ops) or twice (two-product ops);
// the products are combined with the accumulate operand in 34 bits and
// clamped before being handed back over a valid/ready handshake.
//
// Handshake: a request is accepted on a clock edge where valid_i and
// ready_o are high and kill_i is low; a result is consumed on an edge where
// valid_o and ready_i are high and kill_i is low. kill_i outside IDLE drops
// the operation. ready_o is high only in IDLE, valid_o only in DONE.
//
// Build option: define IBEX_PEXT_KHM16_EN to support KHM16/KHMX16 as
// two-product ops with two packed Q15 lanes; otherwise they are unsupported.
module ibex_pext_mult16
   import ibex_pkg_pext::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  zpn_op_e     zpn_operator_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [31:0] op_c_i,
   input  logic        kill_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] result_o,
   output logic        ov_o
);

   // Operator to datapath control.
   function automatic mult16_ctrl_t mult16_decode(input zpn_op_e op);
      mult16_ctrl_t c;
      c           = '0;
      c.supported = 1'b1;
      c.comb_p0   = COMB_ADD;
      case (op)
         ZPN_SMBB16, ZPN_KMABB, ZPN_KHMBB, ZPN_KDMBB, ZPN_KDMABB: c.hsel0 = HSEL_BB;
         ZPN_SMBT16, ZPN_KMABT, ZPN_KHMBT, ZPN_KDMBT, ZPN_KDMABT: c.hsel0 = HSEL_BT;
         ZPN_SMTT16, ZPN_KMATT, ZPN_KHMTT, ZPN_KDMTT, ZPN_KDMATT: c.hsel0 = HSEL_TT;
         ZPN_KMXDA, ZPN_SMXDS, ZPN_KMAXDA, ZPN_KMAXDS, ZPN_KMSXDA, ZPN_KHMX16: begin
            c.hsel0 = HSEL_TB;
            c.hsel1 = HSEL_BT;
         end
         default: begin
            c.hsel0 = HSEL_TT;
            c.hsel1 = HSEL_BB;
         end
      endcase
      case (op)
         ZPN_SMBB16, ZPN_SMBT16, ZPN_SMTT16: c.sat = SAT_NONE;
         ZPN_KMABB, ZPN_KMABT, ZPN_KMATT: begin
            c.comb_c = COMB_ADD;
            c.sat    = SAT_32;
         end
         ZPN_KHMBB, ZPN_KHMBT, ZPN_KHMTT: c.sat = SAT_16_Q15;
         ZPN_KDMBB, ZPN_KDMBT, ZPN_KDMTT: c.sat = SAT_DBL_32;
         ZPN_KDMABB, ZPN_KDMABT, ZPN_KDMATT: begin
            c.comb_c = COMB_ADD;
            c.sat    = SAT_DBL_32;
         end
         ZPN_KMDA, ZPN_KMXDA: begin
            c.two_prod = 1'b1;
            c.comb_p1  = COMB_ADD;
            c.sat      = SAT_32;
         end
         ZPN_SMDS, ZPN_SMXDS: begin
            c.two_prod = 1'b1;
            c.comb_p1  = COMB_SUB;
         end
         ZPN_SMDRS: begin
            c.two_prod = 1'b1;
            c.comb_p0  = COMB_SUB;
            c.comb_p1  = COMB_ADD;
         end
         ZPN_KMADA, ZPN_KMAXDA: begin
            c.two_prod = 1'b1;
            c.comb_c   = COMB_ADD;
            c.comb_p1  = COMB_ADD;
            c.sat      = SAT_32;
         end
         ZPN_KMADS, ZPN_KMAXDS: begin
            c.two_prod = 1'b1;
            c.comb_c   = COMB_ADD;
            c.comb_p1  = COMB_SUB;
            c.sat      = SAT_32;
         end
         ZPN_KMADRS: begin
            c.two_prod = 1'b1;
            c.comb_c   = COMB_ADD;
            c.comb_p0  = COMB_SUB;
            c.comb_p1  = COMB_ADD;
            c.sat      = SAT_32;
         end
         ZPN_KMSDA, ZPN_KMSXDA: begin
            c.two_prod = 1'b1;
            c.comb_c   = COMB_ADD;
            c.comb_p0  = COMB_SUB;
            c.comb_p1  = COMB_SUB;
            c.sat      = SAT_32;
         end
`ifdef IBEX_PEXT_KHM16_EN
         ZPN_KHM16, ZPN_KHMX16: begin
            c.two_prod  = 1'b1;
            c.lane_pack = 1'b1;
            c.sat       = SAT_16_Q15;
         end
`endif
         default: c.supported = 1'b0;
      endcase
      return c;
   endfunction

   // Sign-extended term for the 34-bit accumulator.
   function automatic logic signed [33:0] mult16_term(input logic [31:0] v,
                                                     input mult16_comb_e comb);
      case (comb)
         COMB_ADD: return {{2{v[31]}}, v};
         COMB_SUB: return -{{2{v[31]}}, v};
         default:  return '0;
      endcase
   endfunction

   mult16_state_e state_q;
   mult16_ctrl_t  ctrl_q;
   mult16_ctrl_t  ctrl_in;
   logic [31:0]   a_q, b_q, c_q, p0_q;

   mult16_hsel_e        hsel_cur;
   logic signed [15:0]  mul_a, mul_b;
   logic signed [31:0]  prod;
   logic [31:0]         fp0, fp1;
   logic signed [33:0]  acc, s1_in, s2_in;
   logic [31:0]         s1_sat32, s2_sat32;
   logic [15:0]         s1_sat16, s2_sat16;
   logic                s1_ov32, s2_ov32, s1_ov16, s2_ov16;
   logic [31:0]         res_d;
   logic                ov_d;

   assign ctrl_in = mult16_decode(zpn_operator_i);
   assign ready_o = (state_q == MULT16_IDLE);
   assign valid_o = (state_q == MULT16_DONE);

   // Shared multiplier: operand halves chosen by the product being formed.
   always_comb begin
      hsel_cur = (state_q == MULT16_MUL1) ? ctrl_q.hsel1 : ctrl_q.hsel0;
      mul_a    = (hsel_cur == HSEL_TB || hsel_cur == HSEL_TT) ? a_q[31:16] : a_q[15:0];
      mul_b    = (hsel_cur == HSEL_BT || hsel_cur == HSEL_TT) ? b_q[31:16] : b_q[15:0];
      prod     = mul_a * mul_b;
   end

   // Combine p0/p1/c and prepare the inputs of both clamp stages.
   always_comb begin
      fp0   = ctrl_q.two_prod ? p0_q : prod;
      fp1   = ctrl_q.two_prod ? prod : 32'h0;
      acc   = mult16_term(c_q, ctrl_q.comb_c) + mult16_term(fp0, ctrl_q.comb_p0)
            + mult16_term(fp1, ctrl_q.comb_p1);
      s1_in = acc;
      s2_in = '0;
      case (ctrl_q.sat)
         SAT_DBL_32: begin
            s1_in = {fp0[31], fp0, 1'b0};
            s2_in = (ctrl_q.comb_c != COMB_NONE)
                  ? ({{2{c_q[31]}}, c_q} + {{2{s1_sat32[31]}}, s1_sat32})
                  : {{2{s1_sat32[31]}}, s1_sat32};
         end
         SAT_16_Q15: begin
            s1_in = {{17{fp0[31]}}, fp0[31:15]};
`ifdef IBEX_PEXT_KHM16_EN
            s2_in = {{17{fp1[31]}}, fp1[31:15]};
`endif
         end
         default: s1_in = acc;
      endcase
   end

   ibex_pext_sat u_sat_s1 (
      .value (s1_in),
      .sat32 (s1_sat32),
      .ov32  (s1_ov32),
      .sat16 (s1_sat16),
      .ov16  (s1_ov16)
   );

   ibex_pext_sat u_sat_s2 (
      .value (s2_in),
      .sat32 (s2_sat32),
      .ov32  (s2_ov32),
      .sat16 (s2_sat16),
      .ov16  (s2_ov16)
   );

`ifndef IBEX_PEXT_KHM16_EN
   logic unused_lane;
   assign unused_lane = ^{ctrl_q.lane_pack, s2_sat16, s2_ov16};
`endif

   // Final result and saturation flag selected by the clamp kind.
   always_comb begin
      res_d = '0;
      ov_d  = 1'b0;
      case (ctrl_q.sat)
         SAT_NONE: res_d = acc[31:0];
         SAT_32: begin
            res_d = s1_sat32;
            ov_d  = s1_ov32;
         end
         SAT_DBL_32: begin
            res_d = s2_sat32;
            ov_d  = s1_ov32 | s2_ov32;
         end
         SAT_16_Q15: begin
`ifdef IBEX_PEXT_KHM16_EN
            if (ctrl_q.lane_pack) begin
               res_d = {s1_sat16, s2_sat16};
               ov_d  = s1_ov16 | s2_ov16;
            end else
`endif
            begin
               res_d = {{16{s1_sat16[15]}}, s1_sat16};
               ov_d  = s1_ov16;
            end
         end
         default: res_d = '0;
      endcase
   end

   // Control FSM with operand capture and registered result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= MULT16_IDLE;
         ctrl_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         p0_q     <= '0;
         result_o <= '0;
         ov_o     <= 1'b0;
      end else begin
         case (state_q)
            MULT16_IDLE: begin
               if (valid_i && !kill_i) begin
                  a_q    <= op_a_i;
                  b_q    <= op_b_i;
                  c_q    <= op_c_i;
                  ctrl_q <= ctrl_in;
                  if (ctrl_in.supported) begin
                     state_q <= MULT16_MUL0;
                  end else begin
                     state_q  <= MULT16_DONE;
                     result_o <= '0;
                     ov_o     <= 1'b0;
                  end
               end
            end
            MULT16_MUL0: begin
               if (kill_i) begin
                  state_q <= MULT16_IDLE;
               end else if (ctrl_q.two_prod) begin
                  p0_q    <= prod;
                  state_q <= MULT16_MUL1;
               end else begin
                  result_o <= res_d;
                  ov_o     <= ov_d;
                  state_q  <= MULT16_DONE;
               end
            end
            MULT16_MUL1: begin
               if (kill_i) begin
                  state_q <= MULT16_IDLE;
               end else begin
                  result_o <= res_d;
                  ov_o     <= ov_d;
                  state_q  <= MULT16_DONE;
               end
            end
            MULT16_DONE: begin
               if (kill_i || ready_i) state_q <= MULT16_IDLE;
            end
            default: state_q <= MULT16_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ibex_pext_mult16.sv
// Bench for ibex_pext_mult16: directed steps from the test plan followed by
// randomized operators checked against an arithmetic reference model.
module tb_ibex_pext_mult16;
   import ibex_pkg_pext::*;

   logic        clk;
   logic        rst_ni;
   zpn_op_e     zpn_operator;
   logic        valid_i, ready_o, kill_i, valid_o, ready_i, ov_o;
   logic [31:0] op_a, op_b, op_c, result_o;

   int          errors;
   int          checks;
   logic        m_ov;
   logic [31:0] exp_q[$];

   ibex_pext_mult16 dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .zpn_operator_i (zpn_operator),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .op_a_i         (op_a),
      .op_b_i         (op_b),
      .op_c_i         (op_c),
      .kill_i         (kill_i),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .result_o       (result_o),
      .ov_o           (ov_o)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: signed clamps recording saturation in m_ov
   function automatic longint sat32(input longint v);
      if (v > 64'sd2147483647) begin m_ov = 1'b1; return 64'sd2147483647; end
      if (v < -64'sd2147483648) begin m_ov = 1'b1; return -64'sd2147483648; end
      return v;
   endfunction

   function automatic longint sat16(input longint v);
      if (v > 64'sd32767) begin m_ov = 1'b1; return 64'sd32767; end
      if (v < -64'sd32768) begin m_ov = 1'b1; return -64'sd32768; end
      return v;
   endfunction

   function automatic void model(input zpn_op_e op, input logic [31:0] a, b, c,
                                 output logic [31:0] res, output logic ov, output int lat);
      longint at, ab, bt, bb, cc, ptt, pbb, ptb, pbt, r, h0, h1;
      at  = longint'($signed(a[31:16]));
      ab  = longint'($signed(a[15:0]));
      bt  = longint'($signed(b[31:16]));
      bb  = longint'($signed(b[15:0]));
      cc  = longint'($signed(c));
      ptt = at * bt;  pbb = ab * bb;  ptb = at * bb;  pbt = ab * bt;
      m_ov = 1'b0;
      lat  = 2;
      r    = 0;
      h0   = 0;
      h1   = 0;
      case (op)
         ZPN_SMBB16: r = pbb;
         ZPN_SMBT16: r = pbt;
         ZPN_SMTT16: r = ptt;
         ZPN_KMABB:  r = sat32(cc + pbb);
         ZPN_KMABT:  r = sat32(cc + pbt);
         ZPN_KMATT:  r = sat32(cc + ptt);
         ZPN_KHMBB:  r = sat16(pbb >>> 15);
         ZPN_KHMBT:  r = sat16(pbt >>> 15);
         ZPN_KHMTT:  r = sat16(ptt >>> 15);
         ZPN_KDMBB:  r = sat32(2 * pbb);
         ZPN_KDMBT:  r = sat32(2 * pbt);
         ZPN_KDMTT:  r = sat32(2 * ptt);
         ZPN_KDMABB: r = sat32(cc + sat32(2 * pbb));
         ZPN_KDMABT: r = sat32(cc + sat32(2 * pbt));
         ZPN_KDMATT: r = sat32(cc + sat32(2 * ptt));
         ZPN_KMDA:   begin r = sat32(ptt + pbb); lat = 3; end
         ZPN_KMXDA:  begin r = sat32(ptb + pbt); lat = 3; end
         ZPN_SMDS:   begin r = ptt - pbb; lat = 3; end
         ZPN_SMXDS:  begin r = ptb - pbt; lat = 3; end
         ZPN_SMDRS:  begin r = pbb - ptt; lat = 3; end
         ZPN_KMADA:  begin r = sat32(cc + ptt + pbb); lat = 3; end
         ZPN_KMAXDA: begin r = sat32(cc + ptb + pbt); lat = 3; end
         ZPN_KMADS:  begin r = sat32(cc + ptt - pbb); lat = 3; end
         ZPN_KMAXDS: begin r = sat32(cc + ptb - pbt); lat = 3; end
         ZPN_KMADRS: begin r = sat32(cc - ptt + pbb); lat = 3; end
         ZPN_KMSDA:  begin r = sat32(cc - ptt - pbb); lat = 3; end
         ZPN_KMSXDA: begin r = sat32(cc - ptb - pbt); lat = 3; end
`ifdef IBEX_PEXT_KHM16_EN
         ZPN_KHM16: begin
            h0 = sat16(ptt >>> 15); h1 = sat16(pbb >>> 15);
            r = ((h0 & 64'hffff) << 16) | (h1 & 64'hffff); lat = 3;
         end
         ZPN_KHMX16: begin
            h0 = sat16(ptb >>> 15); h1 = sat16(pbt >>> 15);
            r = ((h0 & 64'hffff) << 16) | (h1 & 64'hffff); lat = 3;
         end
`endif
         default: begin r = 0; lat = 1; end
      endcase
      res = r[31:0];
      ov  = m_ov;
   endfunction

   // Driver: present one request, then wait (bounded) for valid_o
   task automatic run_op(input zpn_op_e op, input logic [31:0] a, b, c,
                         output logic [31:0] res, output logic ov, output int lat);
      @(negedge clk);
      zpn_operator = op;
      op_a = a;  op_b = b;  op_c = c;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      zpn_operator = ZPN_ADD16;
      op_a = $urandom;  op_b = $urandom;  op_c = $urandom;
      lat = 1;
      while (!valid_o && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = result_o;
      ov  = ov_o;
   endtask

   task automatic consume(input string tag);
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      check({tag, "_valid_low"}, {31'b0, valid_o}, 32'h0);
      check({tag, "_ready_high"}, {31'b0, ready_o}, 32'h1);
   endtask

   task automatic directed(input string tag, input zpn_op_e op, input logic [31:0] a, b, c,
                           input logic [31:0] eres, input logic eov, input int elat);
      logic [31:0] res;
      logic        ov;
      int          lat;
      run_op(op, a, b, c, res, ov, lat);
      check({tag, "_lat"}, lat, elat);
      check({tag, "_res"}, res, eres);
      check({tag, "_ov"}, {31'b0, ov}, {31'b0, eov});
      consume(tag);
   endtask

   function automatic logic [15:0] rand_half();
      case ($urandom_range(0, 5))
         0: return 16'h8000;
         1: return 16'h7fff;
         2: return 16'hffff;
         3: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] rand_c();
      case ($urandom_range(0, 3))
         0: return 32'h7fff_ffff;
         1: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      zpn_op_e     all_ops[$];
      zpn_op_e     op;
      logic [31:0] a, b, c, eres, res, held;
      logic        eov, ov;
      int          elat, lat;

      errors = 0;
      checks = 0;
      rst_ni = 1'b0;
      valid_i = 1'b0;  kill_i = 1'b0;  ready_i = 1'b0;
      zpn_operator = ZPN_SMBB16;
      op_a = '0;  op_b = '0;  op_c = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, ready_o}, 32'h1);
      check("rst_valid", {31'b0, valid_o}, 32'h0);
      check("rst_result", result_o, 32'h0);
      check("rst_ov", {31'b0, ov_o}, 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Directed test-plan items
      directed("kmda", ZPN_KMDA, 32'h0003_0002, 32'h0005_0004, 32'h0, 32'h0000_0017, 1'b0, 3);
      directed("khmbb", ZPN_KHMBB, 32'h0000_8000, 32'h0000_8000, 32'h0, 32'h0000_7fff, 1'b1, 2);
      directed("kmada_sat", ZPN_KMADA, 32'h0010_0010, 32'h0010_0010, 32'h7fff_fff0,
               32'h7fff_ffff, 1'b1, 3);
      directed("kmsda_sat", ZPN_KMSDA, 32'h0010_0010, 32'h0010_0010, 32'h8000_0010,
               32'h8000_0000, 1'b1, 3);
      directed("kdmbb_sat", ZPN_KDMBB, 32'h0000_8000, 32'h0000_8000, 32'h0, 32'h7fff_ffff, 1'b1, 2);
      directed("unsup", ZPN_ADD16, 32'h1234_5678, 32'h1111_1111, 32'h5, 32'h0, 1'b0, 1);

      // Result held while the consumer stalls
      run_op(ZPN_SMDRS, 32'h0002_0003, 32'h0004_0005, 32'h0, res, ov, lat);
      check("smdrs_lat", lat, 3);
      check("smdrs_res", res, 32'h0000_0007);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold%0d_res", i), result_o, 32'h0000_0007);
         check($sformatf("hold%0d_ready", i), {31'b0, ready_o}, 32'h0);
         check($sformatf("hold%0d_valid", i), {31'b0, valid_o}, 32'h1);
      end
      consume("smdrs");

      // kill together with valid in IDLE: not accepted
      @(negedge clk);
      zpn_operator = ZPN_KMDA;
      valid_i = 1'b1;
      kill_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      kill_i = 1'b0;
      check("kill_idle_ready", {31'b0, ready_o}, 32'h1);
      check("kill_idle_valid", {31'b0, valid_o}, 32'h0);

      // kill during MUL1 of KMADA
      @(negedge clk);
      zpn_operator = ZPN_KMADA;
      op_a = 32'h0010_0010;  op_b = 32'h0010_0010;  op_c = 32'h0000_0100;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      @(posedge clk);
      #1;
      kill_i = 1'b1;
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      check("kill_mul1_ready", {31'b0, ready_o}, 32'h1);
      check("kill_mul1_valid", {31'b0, valid_o}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("kill_quiet%0d", i), {31'b0, valid_o}, 32'h0);
      end
      directed("smbb16", ZPN_SMBB16, 32'h0000_ffff, 32'h0000_0002, 32'h0, 32'hffff_fffe, 1'b0, 2);

      // Asynchronous reset in MUL0
      @(negedge clk);
      zpn_operator = ZPN_KMDA;
      op_a = 32'h0003_0002;  op_b = 32'h0005_0004;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      check("mul0_busy", {31'b0, ready_o}, 32'h0);
      #1;
      rst_ni = 1'b0;
      #1;
      check("arst_ready", {31'b0, ready_o}, 32'h1);
      check("arst_valid", {31'b0, valid_o}, 32'h0);
      check("arst_result", result_o, 32'h0);
      check("arst_ov", {31'b0, ov_o}, 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;

      // KHM16 lane packing (or unsupported when the option is off)
`ifdef IBEX_PEXT_KHM16_EN
      directed("khm16", ZPN_KHM16, 32'h8000_8000, 32'h8000_8000, 32'h0, 32'h7fff_7fff, 1'b1, 3);
`else
      directed("khm16", ZPN_KHM16, 32'h8000_8000, 32'h8000_8000, 32'h0, 32'h0, 1'b0, 1);
`endif

      // Randomized operators against the reference model
      op = op.first();
      do begin
         all_ops.push_back(op);
         op = op.next();
      end while (op != op.first());
      held = 32'h0;
      for (int i = 0; i < 60; i++) begin
         op = all_ops[$urandom_range(0, all_ops.size() - 1)];
         a  = {rand_half(), rand_half()};
         b  = {rand_half(), rand_half()};
         c  = rand_c();
         model(op, a, b, c, eres, eov, elat);
         exp_q.push_back(eres);
         run_op(op, a, b, c, res, ov, lat);
         held = exp_q.pop_front();
         check($sformatf("rnd%0d_%s_lat", i, op.name()), lat, elat);
         check($sformatf("rnd%0d_%s_res", i, op.name()), res, held);
         check($sformatf("rnd%0d_%s_ov", i, op.name()), {31'b0, ov}, {31'b0, eov});
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            check($sformatf("rnd%0d_stall_res", i), result_o, held);
         end
         ready_i = 1'b1;
         @(posedge clk);
         #1;
         ready_i = 1'b0;
         check($sformatf("rnd%0d_ready", i), {31'b0, ready_o}, 32'h1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
